fp32_mul_round_pack: RTL and testbench

//  Downstream stage of the FP32 multiplier: consumes the 48-bit mantissa product of the 24x24 Vedic array plus upstream sign/exponent/class info.

---
 rtl/fp32_mul_round_pack.sv | 160 ++++++++++++++++
 tb/tb_fp32_mul_round_pack.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_round_pack.sv
// FP32 multiplier back end: normalizes the 48-bit mantissa product, rounds by RISC-V rm, packs binary32.
// Optional macro FP_MUL_FLAGS_EN adds the o_flags {NV,DZ,OF,UF,NX} port, aligned with o_result.
module fp32_mul_round_pack #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 24,
    parameter int ESUM_W = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_in_ready,
    input  logic                     i_sign,
    input  logic [ESUM_W-1:0]        i_exp_sum,
    input  logic [2*MAN_W-1:0]       i_prod,
    input  logic                     i_is_nan,
    input  logic                     i_invalid,
    input  logic                     i_is_inf,
    input  logic                     i_is_zero,
    input  logic [2:0]               i_rm,
    output logic                     o_valid,
    input  logic                     i_out_ready,
    output logic [EXP_W+MAN_W-1:0]   o_result
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [4:0]               o_flags
`endif
);

    localparam int F  = MAN_W - 1;
    localparam int XW = ESUM_W + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic          s1_v, s1_sign, s1_rnd, s1_stk, s1_nan, s1_inf, s1_zero;
    logic [XW-1:0] s1_exp;
    logic [F-1:0]  s1_mant;
    logic [2:0]    s1_rm;
`ifdef FP_MUL_FLAGS_EN
    logic          s1_invalid;
`endif

    logic          s2_adv, s1_adv;
    logic [XW-1:0] exp_ext, norm_exp;
    logic [F-1:0]  norm_mant;
    logic          norm_rnd, norm_stk;

    assign s2_adv     = !o_valid || i_out_ready;
    assign s1_adv     = !s1_v || s2_adv;
    assign o_in_ready = s1_adv;
    assign exp_ext    = {{2{i_exp_sum[ESUM_W-1]}}, i_exp_sum};

    // A product in [2,4) needs one extra right shift and an exponent bump.
    always_comb begin
        if (i_prod[2*MAN_W-1]) begin
            norm_mant = i_prod[2*MAN_W-2 -: F];
            norm_rnd  = i_prod[MAN_W-1];
            norm_stk  = |i_prod[MAN_W-2:0];
            norm_exp  = exp_ext + XW'(1);
        end else begin
            norm_mant = i_prod[2*MAN_W-3 -: F];
            norm_rnd  = i_prod[MAN_W-2];
            norm_stk  = |i_prod[MAN_W-3:0];
            norm_exp  = exp_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= i_valid;
            if (i_valid) begin
                s1_sign <= i_sign;
                s1_exp  <= norm_exp;
                s1_mant <= norm_mant;
                s1_rnd  <= norm_rnd;
                s1_stk  <= norm_stk;
                s1_nan  <= i_is_nan || i_invalid;
                s1_inf  <= i_is_inf;
                s1_zero <= i_is_zero;
                s1_rm   <= i_rm;
`ifdef FP_MUL_FLAGS_EN
                s1_invalid <= i_invalid;
`endif
            end
        end
    end

    logic                   inc, to_inf, overflow, underflow;
    logic [F:0]             rounded;
    logic [XW-1:0]          exp_r;
    logic [EXP_W+MAN_W-1:0] res;

    always_comb begin
        case (s1_rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s1_sign && (s1_rnd || s1_stk);
            3'b011:  inc = !s1_sign && (s1_rnd || s1_stk);
            3'b100:  inc = s1_rnd;
            default: inc = s1_rnd && (s1_stk || s1_mant[0]);
        endcase
        case (s1_rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = s1_sign;
            3'b011:  to_inf = !s1_sign;
            default: to_inf = 1'b1;
        endcase
        // A carry-out only happens from an all-ones fraction, so the low bits are already zero.
        rounded   = {1'b0, s1_mant} + {{F{1'b0}}, inc};
        exp_r     = s1_exp + {{(XW-1){1'b0}}, rounded[F]};
        underflow = exp_r[XW-1] || (exp_r == '0);
        overflow  = !exp_r[XW-1] && (exp_r >= EXP_MAX);

        if (s1_nan)
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
        else if (s1_inf)
            res = {s1_sign, {EXP_W{1'b1}}, {F{1'b0}}};
        else if (s1_zero)
            res = {s1_sign, {(EXP_W+F){1'b0}}};
        else if (overflow)
            res = to_inf ? {s1_sign, {EXP_W{1'b1}}, {F{1'b0}}}
                         : {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}};
        else if (underflow)
            res = {s1_sign, {(EXP_W+F){1'b0}}};
        else
            res = {s1_sign, exp_r[EXP_W-1:0], rounded[F-1:0]};
    end

`ifdef FP_MUL_FLAGS_EN
    logic       special;
    logic [4:0] flags;

    always_comb begin
        special  = s1_nan || s1_inf || s1_zero;
        flags    = 5'b0;
        flags[4] = s1_invalid;
        flags[2] = !special && overflow;
        flags[1] = !special && underflow;
        flags[0] = !special && (s1_rnd || s1_stk || overflow || underflow);
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
`ifdef FP_MUL_FLAGS_EN
            o_flags  <= '0;
`endif
        end else if (s2_adv) begin
            o_valid <= s1_v;
            if (s1_v) begin
                o_result <= res;
`ifdef FP_MUL_FLAGS_EN
                o_flags  <= flags;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Scoreboard bench for fp32_mul_round_pack: a reference model pushes expected results on acceptance,
// the monitor pops them as the DUT hands results downstream.
module tb_fp32_mul_round_pack;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_in_ready;
    logic        i_sign = 1'b0;
    logic [9:0]  i_exp_sum = '0;
    logic [47:0] i_prod = '0;
    logic        i_is_nan = 1'b0;
    logic        i_invalid = 1'b0;
    logic        i_is_inf = 1'b0;
    logic        i_is_zero = 1'b0;
    logic [2:0]  i_rm = 3'b000;
    logic        o_valid;
    logic        i_out_ready = 1'b1;
    logic [31:0] o_result;
`ifdef FP_MUL_FLAGS_EN
    logic [4:0]  o_flags;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    fp32_mul_round_pack dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_sign(i_sign), .i_exp_sum(i_exp_sum), .i_prod(i_prod),
        .i_is_nan(i_is_nan), .i_invalid(i_invalid), .i_is_inf(i_is_inf), .i_is_zero(i_is_zero),
        .i_rm(i_rm), .o_valid(o_valid), .i_out_ready(i_out_ready), .o_result(o_result)
`ifdef FP_MUL_FLAGS_EN
        , .o_flags(o_flags)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference built from integer shifts on the raw product, independent of the bit slicing in the RTL.
    function automatic exp_t model(input logic sign, input int esum, input logic [47:0] prod,
                                   input logic nan, input logic inv, input logic inf,
                                   input logic zero, input logic [2:0] rm);
        exp_t r;
        longint unsigned p, mant, rem, half;
        int sh, e;
        logic rnd, stk, inc, up;
        r.flg = 5'b0;
        r.res = 32'h0;
        if (inv || nan) begin
            r.res    = 32'h7FC00000;
            r.flg[4] = inv;
            return r;
        end
        if (inf) begin
            r.res = {sign, 31'h7F800000};
            return r;
        end
        if (zero) begin
            r.res = {sign, 31'h0};
            return r;
        end
        p    = 64'(prod);
        sh   = prod[47] ? 24 : 23;
        mant = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        rnd  = rem >= half;
        stk  = (rem % half) != 0;
        e    = esum + (prod[47] ? 1 : 0);
        case (rm)
            3'd1:    begin inc = 1'b0;                up = 1'b0;  end
            3'd2:    begin inc = sign & (rnd | stk);  up = sign;  end
            3'd3:    begin inc = !sign & (rnd | stk); up = !sign; end
            3'd4:    begin inc = rnd;                 up = 1'b1;  end
            default: begin inc = rnd & (stk | mant[0]); up = 1'b1; end
        endcase
        mant = mant + 64'(inc);
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) begin
            r.res = up ? {sign, 31'h7F800000} : {sign, 31'h7F7FFFFF};
            r.flg = 5'b00101;
        end else if (e <= 0) begin
            r.res = {sign, 31'h0};
            r.flg = 5'b00011;
        end else begin
            r.res    = {sign, 8'(e), 23'(mant)};
            r.flg[0] = rnd | stk;
        end
        return r;
    endfunction

    // Call just after a posedge; returns just after the posedge where the beat was accepted.
    task automatic applyStimulus(input logic sign, input int esum, input logic [47:0] prod,
                                 input logic nan, input logic inv, input logic inf,
                                 input logic zero, input logic [2:0] rm);
        int waited = 0;
        i_sign = sign; i_exp_sum = 10'(esum); i_prod = prod;
        i_is_nan = nan; i_invalid = inv; i_is_inf = inf; i_is_zero = zero; i_rm = rm;
        i_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_in_ready) begin
                sb.push_back(model(sign, esum, prod, nan, inv, inf, zero, rm));
                @(posedge i_clk);
                #1;
                i_valid = 1'b0;
                break;
            end
            if (++waited > 50) begin
                checkOutput("accept_timeout", 32'(o_in_ready), 32'd1);
                @(posedge i_clk);
                #1;
                i_valid = 1'b0;
                break;
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", 32'(o_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", o_result, e.res);
`ifdef FP_MUL_FLAGS_EN
                checkOutput("flags", 32'(o_flags), 32'(e.flg));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held;
        int wait_cnt;

        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("rst_in_ready", 32'(o_in_ready), 32'd1);

        applyStimulus(0, 127, 48'h900000000000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 127, 48'h400000400000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 127, 48'h400000C00000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 127, 48'h7FFFFFC00000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 254, 48'h800000000000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 254, 48'h800000000000, 0, 0, 0, 0, 3'd1);
        applyStimulus(1, 254, 48'h800000000000, 0, 0, 0, 0, 3'd3);
        applyStimulus(1, 254, 48'h800000000000, 0, 0, 0, 0, 3'd2);
        applyStimulus(0, 254, 48'h800000000000, 0, 0, 0, 0, 3'd2);
        applyStimulus(1, -5, 48'h600000000000, 0, 0, 0, 0, 3'd0);
        applyStimulus(0, 127, 48'h600000000000, 0, 1, 0, 0, 3'd0);
        applyStimulus(1, 127, 48'h600000000000, 1, 0, 0, 0, 3'd0);
        applyStimulus(1, 127, 48'h600000000000, 0, 0, 1, 0, 3'd0);
        applyStimulus(1, 127, 48'h600000000000, 0, 0, 0, 1, 3'd0);
        applyStimulus(0, 127, 48'h400000800000, 0, 0, 0, 0, 3'd4);
        applyStimulus(0, 127, 48'h400000000001, 0, 0, 0, 0, 3'd3);
        applyStimulus(1, 127, 48'h400000000001, 0, 0, 0, 0, 3'd2);
        applyStimulus(0, 127, 48'h400000C00000, 0, 0, 0, 0, 3'd6);

        for (int i = 0; i < 24; i++) begin
            logic [47:0] p;
            p = {$urandom(), $urandom()};
            if (p[47:46] == 2'b00) p[46] = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 280)) - 10, p,
                          0, 0, 0, 1'($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        end

        // Back-to-back burst with a three-cycle downstream stall after the first result appears.
        fork
            begin
                applyStimulus(0, 127, 48'h900000000000, 0, 0, 0, 0, 3'd0);
                applyStimulus(1, 130, 48'hC00000000000, 0, 0, 0, 0, 3'd0);
                applyStimulus(0, 100, 48'h500000000000, 0, 0, 0, 0, 3'd1);
                applyStimulus(1, 90,  48'hA00000000000, 0, 0, 0, 0, 3'd3);
            end
            begin
                wait_cnt = 0;
                @(posedge i_clk);
                #1;
                while (!o_valid && wait_cnt < 20) begin
                    @(posedge i_clk);
                    #1;
                    wait_cnt++;
                end
                checkOutput("burst_first_valid", 32'(o_valid), 32'd1);
                i_out_ready = 1'b0;
                held = o_result;
                @(negedge i_clk);
                checkOutput("stall_in_ready", 32'(o_in_ready), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    checkOutput("stall_hold_result", o_result, held);
                    checkOutput("stall_hold_valid", 32'(o_valid), 32'd1);
                    if (k < 2) @(negedge i_clk);
                end
                @(posedge i_clk);
                #1;
                i_out_ready = 1'b1;
            end
        join

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            @(posedge i_clk);
            #1;
            wait_cnt++;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);

        // Two beats held in the pipe, then reset discards both.
        i_out_ready = 1'b0;
        i_sign = 0; i_exp_sum = 10'd127; i_prod = 48'h900000000000; i_rm = 3'd0;
        i_is_nan = 0; i_invalid = 0; i_is_inf = 0; i_is_zero = 0;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_prod = 48'hC00000000000;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checkOutput("pre_reset_valid", 32'(o_valid), 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("midrst_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst_result", o_result, 32'd0);
        i_rst = 1'b0;
        i_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checkOutput("post_reset_idle", 32'(o_valid), 32'd0);
        end

        @(posedge i_clk);
        #1;
        applyStimulus(0, 127, 48'h900000000000, 0, 0, 0, 0, 3'd0);
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            @(posedge i_clk);
            #1;
            wait_cnt++;
        end
        checkOutput("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
